// File: rtl/button_conditioner_pkg.sv
// Shared constants for the stopwatch front panel: channel map, debounce period
// and which buttons behave as toggles.
package button_conditioner_pkg;

  localparam int unsigned DB_CYCLES_DEFAULT = 500000;

  localparam int unsigned CH_SEL   = 0;
  localparam int unsigned CH_ADJ   = 1;
  localparam int unsigned CH_RST   = 2;
  localparam int unsigned CH_PAUSE = 3;

  localparam logic [3:0] TOGGLE_MASK_DEFAULT = 4'b1000;

  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    return (db_cycles < 2) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw levels in, debounced level/event/toggle vectors out.
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_toggle;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_toggle
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_toggle
  );
endinterface

// File: rtl/button_conditioner_channel.sv
// One button: two-flop synchronizer, stability counter, debounced level and
// registered single-cycle press/release pulses.
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] count;
  logic          accept;

  // The new level is accepted on the same edge the count would reach DB_CYCLES.
  assign accept = (sync2 != stable) && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stable        <= 1'b0;
      count         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= raw;
      sync2         <= sync1;
      press_pulse   <= accept && !stable;
      release_pulse <= accept && stable;
      if (sync2 == stable) begin
        count <= '0;
      end else if (accept) begin
        stable <= ~stable;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN push buttons independently and keeps toggle latches for the
// channels selected by TOGGLE_MASK.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned          N_BTN       = 4,
  parameter int unsigned          DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter logic [N_BTN-1:0]     TOGGLE_MASK = N_BTN'(TOGGLE_MASK_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] toggle_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .raw           (bus.btn_raw[i]),
      .level         (level_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (release_v[i])
    );
  end

  // Unmasked bits never see a press term, so they hold their reset value of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ (press_v & TOGGLE_MASK);
    end
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = release_v;
  assign bus.btn_toggle  = toggle_q;

endmodule
